// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a synchronous-read instruction
// memory with a 1-cycle read latency. It issues a fetch address every cycle,
// tracks which PC the returning word belongs to, and hands instruction and PC
// to decode under a valid/ready handshake. It also handles redirects and halt,
// and keeps counters of fetched instructions and stalled cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | fetching; a word is presented to decode whenever resp_valid_q
// ST_HALT | fetch stopped; only redirect_i or rst_i leaves this state
module fetch_ctrl #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ready_i,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    input  logic                   halt_i,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic [ADDR_WIDTH-1:0]  pc_plus4_o,
    output logic                   misalign_o,
    output logic [31:0]            fetch_cnt_o,
    output logic [31:0]            stall_cnt_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]   resp_pc_q, resp_pc_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    misalign_q;
    logic [31:0]             fetch_cnt_q, stall_cnt_q;

    logic                    in_run;
    logic                    stall;
    logic [ADDR_WIDTH-1:0]   tgt;

    assign in_run = (state_q == ST_RUN);
    assign stall  = resp_valid_q & ~ready_i;
    assign tgt    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

    // Fetch address: a stalled word is re-read so imem_rdata_i stays stable
    // without needing a skid buffer.
    always_comb begin
        imem_addr_o = fetch_pc_q;
        if (redirect_i) begin
            imem_addr_o = tgt;
        end else if (in_run && stall) begin
            imem_addr_o = resp_pc_q;
        end
    end

    // Decode-facing outputs; the wrong-path word is squashed in the redirect
    // cycle, and everything reads as idle while reset is held.
    always_comb begin
        valid_o     = ~rst_i & in_run & resp_valid_q & ~redirect_i;
        instr_o     = imem_rdata_i;
        pc_o        = rst_i ? '0 : resp_pc_q;
        pc_plus4_o  = pc_o + PC_STEP;
        misalign_o  = misalign_q & ~rst_i;
        fetch_cnt_o = fetch_cnt_q;
        stall_cnt_o = stall_cnt_q;
    end

    // Next-state: redirect beats halt, halt beats stall, otherwise advance.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        if (redirect_i) begin
            state_d      = ST_RUN;
            resp_pc_d    = tgt;
            resp_valid_d = 1'b1;
            fetch_pc_d   = tgt + PC_STEP;
        end else if (in_run) begin
            if (halt_i) begin
                state_d      = ST_HALT;
                resp_valid_d = 1'b0;
            end else if (!stall) begin
                resp_pc_d    = fetch_pc_q;
                resp_valid_d = 1'b1;
                fetch_pc_d   = fetch_pc_q + PC_STEP;
            end
        end
    end

    // State, PC tracking, misalign flag and performance counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= '0;
            resp_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            fetch_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            misalign_q   <= redirect_i & (redirect_pc_i[1:0] != 2'b00);
            if (valid_o && ready_i) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (valid_o && !ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus a randomized run, all
// checked against a cycle-level behavioural model of the fetch stream.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i, rst_i, ready_i, redirect_i, halt_i;
    logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i;
    logic        valid_o, misalign_o;
    logic [31:0] instr_o, pc_o, pc_plus4_o, fetch_cnt_o, stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ready_i(ready_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
        .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .misalign_o(misalign_o), .fetch_cnt_o(fetch_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk_i) imem_rdata_i <= mem_word(imem_addr_o);

    // Model: the word on offer (m_cur/m_cur_v), the next sequential address,
    // halt flag, counters, and the address whose data is on the memory bus.
    logic [31:0] m_next, m_cur, m_fcnt, m_scnt, m_last_addr;
    logic        m_cur_v, m_halt, m_mis;
    logic        e_valid, e_mis;
    logic [31:0] e_addr, e_pc, e_instr;

    task automatic apply(input logic r, input logic rdy, input logic rd,
                         input logic [31:0] rpc, input logic h);
        logic [31:0] t;
        rst_i = r; ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc; halt_i = h;
        t       = {rpc[31:2], 2'b00};
        e_valid = !r && !m_halt && m_cur_v && !rd;
        if (rd)                                e_addr = t;
        else if (!m_halt && m_cur_v && !rdy)   e_addr = m_cur;
        else                                   e_addr = m_next;
        e_pc    = r ? 32'h0 : m_cur;
        e_mis   = r ? 1'b0 : m_mis;
        e_instr = mem_word(m_last_addr);
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        m_last_addr = e_addr;
        if (rst_i) begin
            m_next = RESET_PC; m_cur = 0; m_cur_v = 0; m_halt = 0;
            m_fcnt = 0; m_scnt = 0; m_mis = 0;
        end else begin
            if (e_valid && ready_i)  m_fcnt = m_fcnt + 1;
            if (e_valid && !ready_i) m_scnt = m_scnt + 1;
            m_mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (redirect_i) begin
                m_cur = {redirect_pc_i[31:2], 2'b00};
                m_cur_v = 1; m_next = m_cur + 4; m_halt = 0;
            end else if (m_halt) begin
            end else if (halt_i) begin
                m_halt = 1; m_cur_v = 0;
            end else if (!(m_cur_v && !ready_i)) begin
                m_cur = m_next; m_cur_v = 1; m_next = m_next + 4;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 1, 0, 0, 0);
            n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
            n_checks++; if (pc_o !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h exp 0", pc_o); end
            n_checks++; if (misalign_o !== 1'b0) begin n_errors++; $display("FAIL reset_misalign: got %b exp 0", misalign_o); end
            tick();
        end
        apply(0, 1, 0, 0, 0);
        n_checks++; if (fetch_cnt_o !== 0 || stall_cnt_o !== 0) begin n_errors++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", fetch_cnt_o, stall_cnt_o); end
    endtask

    task automatic test_sequential();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (valid_o !== 1'b0 || imem_addr_o !== RESET_PC) begin n_errors++; $display("FAIL seq_first: got valid=%b addr=%h exp 0/%h", valid_o, imem_addr_o, RESET_PC); end
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 0, 0, 0);
            n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'(4*i)) begin n_errors++; $display("FAIL seq_pc: got valid=%b pc=%h exp 1/%h", valid_o, pc_o, 32'(4*i)); end
            n_checks++; if (instr_o !== mem_word(32'(4*i))) begin n_errors++; $display("FAIL seq_instr: got %h exp %h", instr_o, mem_word(32'(4*i))); end
            n_checks++; if (pc_plus4_o !== 32'(4*i+4) || imem_addr_o !== 32'(4*i+4)) begin n_errors++; $display("FAIL seq_addr: got plus4=%h addr=%h exp %h", pc_plus4_o, imem_addr_o, 32'(4*i+4)); end
            tick();
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 0, 0, 0);
            n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8 || imem_addr_o !== 32'h8) begin n_errors++; $display("FAIL stall_hold: got valid=%b pc=%h addr=%h exp 1/8/8", valid_o, pc_o, imem_addr_o); end
            n_checks++; if (instr_o !== mem_word(32'h8)) begin n_errors++; $display("FAIL stall_instr: got %h exp %h", instr_o, mem_word(32'h8)); end
            tick();
        end
        apply(0, 1, 0, 0, 0);
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8) begin n_errors++; $display("FAIL stall_release: got valid=%b pc=%h exp 1/8", valid_o, pc_o); end
        n_checks++; if (stall_cnt_o !== 32'd3) begin n_errors++; $display("FAIL stall_cnt: got %0d exp 3", stall_cnt_o); end
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'hC) begin n_errors++; $display("FAIL stall_next: got valid=%b pc=%h exp 1/c", valid_o, pc_o); end
        tick();
    endtask

    task automatic test_redirect();
        logic [31:0] f0;
        apply(0, 1, 1, 32'h100, 0);
        f0 = fetch_cnt_o;
        n_checks++; if (pc_o !== 32'h10 || valid_o !== 1'b0 || imem_addr_o !== 32'h100) begin n_errors++; $display("FAIL redir_squash: got pc=%h valid=%b addr=%h exp 10/0/100", pc_o, valid_o, imem_addr_o); end
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h100) begin n_errors++; $display("FAIL redir_target: got valid=%b pc=%h exp 1/100", valid_o, pc_o); end
        n_checks++; if (fetch_cnt_o !== f0) begin n_errors++; $display("FAIL redir_fcnt: got %0d exp %0d", fetch_cnt_o, f0); end
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h104) begin n_errors++; $display("FAIL redir_next: got valid=%b pc=%h exp 1/104", valid_o, pc_o); end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] s0;
        apply(0, 0, 1, 32'h102, 0);
        s0 = m_scnt;
        n_checks++; if (valid_o !== 1'b0 || imem_addr_o !== 32'h100) begin n_errors++; $display("FAIL rs_cycle: got valid=%b addr=%h exp 0/100", valid_o, imem_addr_o); end
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (misalign_o !== 1'b1) begin n_errors++; $display("FAIL rs_misalign: got %b exp 1", misalign_o); end
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h100) begin n_errors++; $display("FAIL rs_target: got valid=%b pc=%h exp 1/100", valid_o, pc_o); end
        n_checks++; if (stall_cnt_o !== s0) begin n_errors++; $display("FAIL rs_scnt: got %0d exp %0d", stall_cnt_o, s0); end
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (misalign_o !== 1'b0 || pc_o !== 32'h104) begin n_errors++; $display("FAIL rs_after: got mis=%b pc=%h exp 0/104", misalign_o, pc_o); end
    endtask

    task automatic test_halt();
        logic [31:0] f0;
        tick();
        apply(0, 1, 0, 0, 1);
        f0 = m_fcnt;
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h108) begin n_errors++; $display("FAIL halt_cycle: got valid=%b pc=%h exp 1/108", valid_o, pc_o); end
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(0, 1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)));
            n_checks++; if (valid_o !== 1'b0 || imem_addr_o !== 32'h10C) begin n_errors++; $display("FAIL halt_frozen: got valid=%b addr=%h exp 0/10c", valid_o, imem_addr_o); end
            n_checks++; if (fetch_cnt_o !== f0 + 1) begin n_errors++; $display("FAIL halt_fcnt: got %0d exp %0d", fetch_cnt_o, f0 + 1); end
            tick();
        end
        apply(0, 1, 1, 32'h40, 0);
        n_checks++; if (valid_o !== 1'b0 || imem_addr_o !== 32'h40) begin n_errors++; $display("FAIL halt_redir: got valid=%b addr=%h exp 0/40", valid_o, imem_addr_o); end
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h40 || instr_o !== mem_word(32'h40)) begin n_errors++; $display("FAIL halt_resume: got valid=%b pc=%h instr=%h exp 1/40/%h", valid_o, pc_o, instr_o, mem_word(32'h40)); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        int guard;
        apply(1, 1, 0, 0, 0);
        tick();
        guard = 0;
        while (m_fcnt < 5 && guard < 20) begin
            apply(0, 1, 0, 0, 0);
            tick();
            guard++;
        end
        apply(0, 0, 0, 0, 0);
        n_checks++; if (fetch_cnt_o !== 32'd5) begin n_errors++; $display("FAIL rms_fcnt: got %0d exp 5", fetch_cnt_o); end
        tick();
        apply(1, 0, 0, 0, 0);
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL rms_during: got valid=%b exp 0", valid_o); end
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (valid_o !== 1'b0 || imem_addr_o !== RESET_PC) begin n_errors++; $display("FAIL rms_after: got valid=%b addr=%h exp 0/%h", valid_o, imem_addr_o, RESET_PC); end
        n_checks++; if (fetch_cnt_o !== 0 || stall_cnt_o !== 0) begin n_errors++; $display("FAIL rms_counters: got %0d/%0d exp 0/0", fetch_cnt_o, stall_cnt_o); end
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (valid_o !== 1'b1 || pc_o !== RESET_PC) begin n_errors++; $display("FAIL rms_restart: got valid=%b pc=%h exp 1/%h", valid_o, pc_o, RESET_PC); end
        tick();
    endtask

    task automatic test_wrap();
        apply(0, 1, 1, 32'hFFFF_FFF8, 0);
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (pc_o !== 32'hFFFF_FFF8) begin n_errors++; $display("FAIL wrap_f8: got %h exp fffffff8", pc_o); end
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0 || imem_addr_o !== 32'h0) begin n_errors++; $display("FAIL wrap_fc: got pc=%h plus4=%h addr=%h exp fffffffc/0/0", pc_o, pc_plus4_o, imem_addr_o); end
        tick();
        apply(0, 1, 0, 0, 0);
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== mem_word(32'h0)) begin n_errors++; $display("FAIL wrap_zero: got valid=%b pc=%h instr=%h", valid_o, pc_o, instr_o); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            apply(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 70),
                  ($urandom_range(0, 99) < 6), $urandom, ($urandom_range(0, 99) < 3));
            n_checks++; if (valid_o !== e_valid) begin n_errors++; $display("FAIL rnd_valid @%0d: got %b exp %b", n, valid_o, e_valid); end
            n_checks++; if (imem_addr_o !== e_addr) begin n_errors++; $display("FAIL rnd_addr @%0d: got %h exp %h", n, imem_addr_o, e_addr); end
            n_checks++; if (pc_o !== e_pc || pc_plus4_o !== e_pc + 32'd4) begin n_errors++; $display("FAIL rnd_pc @%0d: got %h/%h exp %h", n, pc_o, pc_plus4_o, e_pc); end
            if (e_valid) begin
                n_checks++; if (instr_o !== e_instr) begin n_errors++; $display("FAIL rnd_instr @%0d: got %h exp %h", n, instr_o, e_instr); end
            end
            n_checks++; if (misalign_o !== e_mis) begin n_errors++; $display("FAIL rnd_misalign @%0d: got %b exp %b", n, misalign_o, e_mis); end
            n_checks++; if (fetch_cnt_o !== m_fcnt || stall_cnt_o !== m_scnt) begin n_errors++; $display("FAIL rnd_counters @%0d: got %0d/%0d exp %0d/%0d", n, fetch_cnt_o, stall_cnt_o, m_fcnt, m_scnt); end
            tick();
        end
    endtask

    initial begin
        rst_i = 1'b1; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0;
        m_next = RESET_PC; m_cur = 0; m_cur_v = 0; m_halt = 0;
        m_fcnt = 0; m_scnt = 0; m_mis = 0; m_last_addr = 0;
        @(negedge clk_i);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_halt();
        test_reset_mid_stall();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
